demux1_4_reg: RTL and testbench

- 1-to-4 registered stream demultiplexer; the distribution-side counterpart of the team's 4:1 mux.
- A single valid/ready input stream is routed by a 2-bit select to one of four output lanes.
- Each lane has a one-entry output register, so lanes stall independently.
- Sits between a shared producer and four independent consumers.

---
 rtl/demux1_4_reg.sv | 126 ++++++++++++
 tb/tb_demux1_4_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/demux1_4_reg.sv
// demux1_4_reg: 1-to-4 registered valid/ready stream demultiplexer.
// A single input stream is steered by in_sel to one of four lanes. Each lane
// owns a one-entry output register, so a stalled consumer only blocks beats
// addressed to its own lane.
//
// Optional feature macro: DEMUX_CNT_EN adds per-lane accepted-beat counters
// on lane_cnt (modulo 2^CNT_W). Without it the port and counters are absent.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   combinational: selected lane can take a beat this cycle
//   in_data    input beat data (DATA_W)
//   in_sel     destination lane index
//   out_valid  bit k: lane k register holds a beat
//   out_ready  bit k: lane k consumer accepts
//   out_data   lane k data at [k*DATA_W +: DATA_W]
//   lane_cnt   lane k counter at [k*CNT_W +: CNT_W] (DEMUX_CNT_EN only)
module demux1_4_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [1:0]            in_sel,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [4*DATA_W-1:0]   out_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [4*CNT_W-1:0]    lane_cnt
`endif
);

  localparam int unsigned LANES = 4;

  // Elaboration-time parameter sanity.
  if (DATA_W < 1) begin : g_bad_data_w
    $error("demux1_4_reg: DATA_W must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("demux1_4_reg: CNT_W must be at least 1");
  end

  logic [LANES-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [LANES];
  logic [LANES-1:0]  lane_hit;
  logic [LANES-1:0]  lane_free;
  logic [LANES-1:0]  lane_load;
  logic              accept;

  // Lane decode and per-lane readiness; a lane is free when empty or draining.
  always_comb begin
    lane_hit  = '0;
    lane_free = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_hit[k]  = (in_sel == 2'(k));
      lane_free[k] = ~valid_q[k] | out_ready[k];
    end
  end

  // in_ready deliberately has no path from in_valid.
  assign in_ready  = lane_free[in_sel];
  assign accept    = in_valid & in_ready;
  assign lane_load = lane_hit & {LANES{accept}};

  // Lane registers: load wins over drain, so drain+load keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < LANES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_load[k]) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
        end else if (valid_q[k] & out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // Flatten lane registers onto the output bus.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < LANES; k++) begin
      out_data[k*DATA_W +: DATA_W] = data_q[k];
    end
  end

  assign out_valid = valid_q;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [LANES];

  // Accepted-beat counters, wrapping; updated on the same edge as the lane load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_load[k]) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    lane_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_demux1_4_reg.sv
// tb_demux1_4_reg: directed self-checking bench for demux1_4_reg.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_demux1_4_reg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [1:0]          in_sel;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready;
  logic [4*DATA_W-1:0] out_data;
`ifdef DEMUX_CNT_EN
  logic [4*CNT_W-1:0]  lane_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int seen77 = 0;

  demux1_4_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_CNT_EN
    ,
    .lane_cnt  (lane_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts consumer handshakes on lane 2 carrying 0x77.
  always @(posedge clk) begin
    if (rst_n && out_valid[2] && out_ready[2] && out_data[2*DATA_W +: DATA_W] == 8'h77)
      seen77 = seen77 + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] lane(input int k);
    return out_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 2'd0);
    out_ready = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    check("reset_valid", 64'(out_valid), 64'(4'b0000));
    check("reset_data", 64'(out_data), 64'(0));
    check("reset_ready", 64'(in_ready), 64'(1));
    tick();
    tick();
    rst_n = 1'b1;

    // Basic routing: one beat per lane, all consumers ready.
    out_ready = 4'b1111;
    drive(1'b1, 8'h11, 2'd0);
    #1 check("route_ready", 64'(in_ready), 64'(1));
    tick();
    check("route0_valid", 64'(out_valid), 64'(4'b0001));
    check("route0_data", 64'(lane(0)), 64'(8'h11));
    drive(1'b1, 8'h22, 2'd1);
    tick();
    check("route1_valid", 64'(out_valid), 64'(4'b0010));
    check("route1_data", 64'(lane(1)), 64'(8'h22));
    drive(1'b1, 8'h33, 2'd2);
    tick();
    check("route2_valid", 64'(out_valid), 64'(4'b0100));
    check("route2_data", 64'(lane(2)), 64'(8'h33));
    drive(1'b1, 8'h44, 2'd3);
    tick();
    check("route3_valid", 64'(out_valid), 64'(4'b1000));
    check("route3_data", 64'(lane(3)), 64'(8'h44));
    drive(1'b0, 8'h00, 2'd0);
    tick();
    check("route_idle", 64'(out_valid), 64'(4'b0000));

    // Lane stall isolation: lane 1 consumer stops.
    out_ready = 4'b1101;
    drive(1'b1, 8'h22, 2'd1);
    tick();
    check("stall_load_valid", 64'(out_valid), 64'(4'b0010));
    drive(1'b1, 8'h55, 2'd1);
    #1 check("stall_ready_low", 64'(in_ready), 64'(0));
    tick();
    check("stall_hold_valid", 64'(out_valid), 64'(4'b0010));
    check("stall_hold_data", 64'(lane(1)), 64'(8'h22));
    drive(1'b1, 8'h66, 2'd3);
    #1 check("other_lane_ready", 64'(in_ready), 64'(1));
    tick();
    check("other_lane_valid", 64'(out_valid), 64'(4'b1010));
    check("other_lane_data", 64'(lane(3)), 64'(8'h66));
    check("stall_data_kept", 64'(lane(1)), 64'(8'h22));
    drive(1'b0, 8'h00, 2'd0);
    tick();
    check("other_lane_drain", 64'(out_valid), 64'(4'b0010));
    out_ready = 4'b1111;
    tick();
    check("stall_release", 64'(out_valid), 64'(4'b0000));
    check("drained_data_held", 64'(lane(1)), 64'(8'h22));

    // Same-lane streaming: back-to-back beats into lane 0.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 2'd0);
      #1 check("stream_ready", 64'(in_ready), 64'(1));
      tick();
      check("stream_valid", 64'(out_valid), 64'(4'b0001));
      check("stream_data", 64'(lane(0)), 64'(i));
    end
    drive(1'b0, 8'h00, 2'd0);
    tick();
    check("stream_end", 64'(out_valid), 64'(4'b0000));

    // Simultaneous drain and load on lane 2.
    out_ready = 4'b1011;
    drive(1'b1, 8'h77, 2'd2);
    tick();
    drive(1'b0, 8'h00, 2'd0);
    tick();
    check("dl_hold_valid", 64'(out_valid), 64'(4'b0100));
    check("dl_hold_data", 64'(lane(2)), 64'(8'h77));
    out_ready = 4'b1111;
    drive(1'b1, 8'h88, 2'd2);
    #1 check("dl_ready", 64'(in_ready), 64'(1));
    tick();
    check("dl_new_valid", 64'(out_valid), 64'(4'b0100));
    check("dl_new_data", 64'(lane(2)), 64'(8'h88));
    drive(1'b0, 8'h00, 2'd0);
    tick();
    check("dl_drained", 64'(out_valid), 64'(4'b0000));
    check("dl_consumed_once", 64'(seen77), 64'(1));

    // Full lane, no drain: in_ready low and nothing changes.
    out_ready = 4'b0000;
    drive(1'b1, 8'hA5, 2'd2);
    tick();
    drive(1'b1, 8'h5A, 2'd2);
    #1 check("full_ready_low", 64'(in_ready), 64'(0));
    tick();
    check("full_valid", 64'(out_valid), 64'(4'b0100));
    check("full_data", 64'(lane(2)), 64'(8'hA5));
    drive(1'b0, 8'h00, 2'd0);

    // Reset mid-cycle with lane 2 holding 0xA5: clears without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("midreset_valid", 64'(out_valid), 64'(4'b0000));
    check("midreset_data", 64'(out_data), 64'(0));
    check("midreset_ready", 64'(in_ready), 64'(1));
    tick();
    rst_n = 1'b1;
    #1 check("post_reset_ready", 64'(in_ready), 64'(1));
`ifdef DEMUX_CNT_EN
    check("cnt_reset", 64'(lane_cnt), 64'(0));
    // Counter wrap: 17 beats into lane 3 with CNT_W=4 leaves 1.
    out_ready = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(i), 2'd3);
      tick();
    end
    drive(1'b0, 8'h00, 2'd0);
    check("cnt_lane3_wrap", 64'(lane_cnt[3*CNT_W +: CNT_W]), 64'(1));
    check("cnt_others", 64'(lane_cnt[0 +: 3*CNT_W]), 64'(0));
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
